// File: rtl/sync_pkg.sv
// Shared types for the frame-level sequencer of the game-of-life pipeline.
// The optional frame counter in synchronizer is guarded by SYNC_FRAME_CNT_EN.
package sync_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_READY = 3'd3,
    S_SWAP  = 3'd4
  } sync_state_t;

  localparam int unsigned SYNC_FRAME_CNT_W_DEF = 16;

endpackage

// File: rtl/sync_done_latch.sv
// Sticky done flag: set_in latches high, clr_in (priority) or rst_in clears it.
// Lets the sequencer accept done as either a pulse or a level.
module sync_done_latch (
  input  logic clk_in,
  input  logic rst_in,
  input  logic set_in,
  input  logic clr_in,
  output logic q_out
);

  logic r_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      r_q <= 1'b0;
    end else if (set_in) begin
      r_q <= 1'b1;
    end
  end

  assign q_out = r_q;

endmodule

// File: rtl/synchronizer.sv
// Frame sequencer: start logic+render together, wait for both done and buffer ready, swap, repeat.
// Optional completed-swap counter on frame_cnt_out when SYNC_FRAME_CNT_EN is defined.
//
//  state   | meaning
//  S_IDLE  | held in reset / first cycle after release
//  S_START | one-cycle start pulse to logic engine and renderer, done flags cleared
//  S_WAIT  | collecting logic/render done (either order, or together)
//  S_READY | both done, waiting for buf_ready_in
//  S_SWAP  | one-cycle buffer swap pulse, then next frame starts
module synchronizer
  import sync_pkg::*;
#(
  parameter int unsigned FRAME_CNT_W = SYNC_FRAME_CNT_W_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   logic_done_in,
  input  logic                   render_done_in,
  input  logic                   buf_ready_in,
  output logic                   logic_start_out,
  output logic                   render_start_out,
`ifdef SYNC_FRAME_CNT_EN
  output logic                   buf_swap_out,
  output logic [FRAME_CNT_W-1:0] frame_cnt_out
`else
  output logic                   buf_swap_out
`endif
);

  sync_state_t r_state;
  sync_state_t w_state_nxt;

  logic w_ldone;
  logic w_rdone;
  logic w_in_wait;
  logic w_clr_flags;
  logic w_both_done;
  logic w_start;
  logic w_swap;

  assign w_in_wait   = (r_state == S_WAIT);
  assign w_clr_flags = (r_state == S_START);

  // Done inputs are only captured while waiting, so anything seen during START is dropped.
  sync_done_latch u_logic_done (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .set_in (w_in_wait & logic_done_in),
    .clr_in (w_clr_flags),
    .q_out  (w_ldone)
  );

  sync_done_latch u_render_done (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .set_in (w_in_wait & render_done_in),
    .clr_in (w_clr_flags),
    .q_out  (w_rdone)
  );

  assign w_both_done = (w_ldone | logic_done_in) & (w_rdone | render_done_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_both_done) w_state_nxt = S_READY;
      S_READY: if (buf_ready_in) w_state_nxt = S_SWAP;
      S_SWAP:  w_state_nxt = S_START;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_swap  = 1'b0;
    case (r_state)
      S_START: w_start = 1'b1;
      S_SWAP:  w_swap  = 1'b1;
      default: ;
    endcase
  end

  assign logic_start_out  = w_start;
  assign render_start_out = w_start;
  assign buf_swap_out     = w_swap;

`ifdef SYNC_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Free-running wrap modulo 2**FRAME_CNT_W.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_frame_cnt <= '0;
    end else if (w_swap) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_cnt_out = r_frame_cnt;
`endif

  a_width_ok : assert property (@(posedge clk_in) FRAME_CNT_W > 0);
  a_excl     : assert property (@(posedge clk_in) disable iff (rst_in) !(w_start && w_swap));

endmodule

// File: tb/tb_synchronizer.sv
// Self-checking bench for synchronizer: directed scenarios plus random stimulus against a
// cycle-index scoreboard. Two instances share stimulus: default counter width and width 2.
module tb_synchronizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ld, rd, br;
  logic ls_a, rs_a, sw_a, ls_b, rs_b, sw_b;
`ifdef SYNC_FRAME_CNT_EN
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard: cycle index of the pending start pulse, of both-done, and of the swap pulse.
  int t_start = -100;
  int t_done  = -1;
  int t_swap  = -1;
  bit seen_l, seen_r;
  int unsigned m_frames = 0;
  bit exp_start, exp_swap;

  synchronizer #(.FRAME_CNT_W(16)) dut (
    .clk_in(clk), .rst_in(rst), .logic_done_in(ld), .render_done_in(rd), .buf_ready_in(br),
    .logic_start_out(ls_a), .render_start_out(rs_a),
`ifdef SYNC_FRAME_CNT_EN
    .buf_swap_out(sw_a), .frame_cnt_out(cnt_a)
`else
    .buf_swap_out(sw_a)
`endif
  );

  synchronizer #(.FRAME_CNT_W(2)) dut_w2 (
    .clk_in(clk), .rst_in(rst), .logic_done_in(ld), .render_done_in(rd), .buf_ready_in(br),
    .logic_start_out(ls_b), .render_start_out(rs_b),
`ifdef SYNC_FRAME_CNT_EN
    .buf_swap_out(sw_b), .frame_cnt_out(cnt_b)
`else
    .buf_swap_out(sw_b)
`endif
  );

  task automatic model_expect();
    exp_start = (cyc == t_start);
    exp_swap  = (cyc == t_swap);
  endtask

  // Consume this cycle's inputs into the scoreboard, then move to the next cycle.
  task automatic advance();
    if (rst) begin
      t_start = cyc + 2; t_done = -1; t_swap = -1;
      seen_l = 1'b0; seen_r = 1'b0; m_frames = 0;
    end else if (cyc == t_swap) begin
      m_frames++;
      t_start = cyc + 1; t_done = -1; t_swap = -1;
      seen_l = 1'b0; seen_r = 1'b0;
    end else if (cyc > t_start && t_done < 0) begin
      seen_l = seen_l | ld;
      seen_r = seen_r | rd;
      if (seen_l && seen_r) t_done = cyc;
    end else if (t_done >= 0 && cyc > t_done && t_swap < 0 && br) begin
      t_swap = cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int first_start = -1;
    int n_start = 0;
    ld = 0; rd = 0; br = 0;
    for (int k = 0; k < 9; k++) begin
      rst = (k < 2);
      if (k > 0) begin
        model_expect();
        checks++;
        if ({ls_a, rs_a, sw_a, ls_b, rs_b, sw_b} !== {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap}) begin
          errors++;
          $display("FAIL reset_pulses k=%0d got=%b exp=%b", k, {ls_a, rs_a, sw_a, ls_b, rs_b, sw_b}, {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap});
        end
        if (ls_a) begin
          n_start++;
          if (first_start < 0) first_start = k;
        end
      end
      advance();
    end
    checks++;
    if (first_start !== 3 || n_start !== 1) begin
      errors++;
      $display("FAIL reset_first_start got k=%0d n=%0d exp k=3 n=1", first_start, n_start);
    end
  endtask

  task automatic test_seq_done();
    int first_swap = -1;
    int n_swap = 0;
    int start_after = -1;
    for (int k = 0; k < 14; k++) begin
      rst = (k == 0); ld = (k == 4); rd = (k == 7); br = 1'b1;
      model_expect();
      checks++;
      if ({ls_a, rs_a, sw_a, ls_b, rs_b, sw_b} !== {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap}) begin
        errors++;
        $display("FAIL seq_done_pulses k=%0d got=%b exp=%b", k, {ls_a, rs_a, sw_a, ls_b, rs_b, sw_b}, {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap});
      end
      if (sw_a) begin
        n_swap++;
        if (first_swap < 0) first_swap = k;
      end
      if (ls_a && first_swap >= 0 && start_after < 0) start_after = k;
      advance();
    end
    checks++;
    if (first_swap !== 9 || n_swap !== 1 || start_after !== 10) begin
      errors++;
      $display("FAIL seq_done_timing got swap=%0d n=%0d start=%0d exp swap=9 n=1 start=10", first_swap, n_swap, start_after);
    end
  endtask

  task automatic test_ready_late();
    int first_swap = -1;
    int n_swap = 0;
    for (int k = 0; k < 16; k++) begin
      rst = (k == 0); ld = (k == 4); rd = (k == 4); br = (k >= 10);
      model_expect();
      checks++;
      if ({ls_a, rs_a, sw_a, ls_b, rs_b, sw_b} !== {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap}) begin
        errors++;
        $display("FAIL ready_late_pulses k=%0d got=%b exp=%b", k, {ls_a, rs_a, sw_a, ls_b, rs_b, sw_b}, {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap});
      end
      if (sw_a) begin
        n_swap++;
        if (first_swap < 0) first_swap = k;
      end
      advance();
    end
    checks++;
    if (first_swap !== 11 || n_swap !== 1) begin
      errors++;
      $display("FAIL ready_late_timing got swap=%0d n=%0d exp swap=11 n=1", first_swap, n_swap);
    end
  endtask

  task automatic test_back_to_back();
    int last_swap = -1;
    int n_swap = 0;
    int bad_gap = 0;
    for (int k = 0; k < 27; k++) begin
      rst = (k == 0); ld = (k > 0); rd = (k > 0); br = (k > 0);
      model_expect();
      checks++;
      if ({ls_a, rs_a, sw_a, ls_b, rs_b, sw_b} !== {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap}) begin
        errors++;
        $display("FAIL b2b_pulses k=%0d got=%b exp=%b", k, {ls_a, rs_a, sw_a, ls_b, rs_b, sw_b}, {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap});
      end
`ifdef SYNC_FRAME_CNT_EN
      if (k > 0) begin
        checks++;
        if (cnt_a !== 16'(m_frames) || cnt_b !== 2'(m_frames)) begin
          errors++;
          $display("FAIL b2b_count k=%0d got=%0d/%0d exp=%0d/%0d", k, cnt_a, cnt_b, 16'(m_frames), 2'(m_frames));
        end
      end
`endif
      if (sw_a) begin
        if (last_swap >= 0 && k - last_swap != 4) bad_gap++;
        last_swap = k;
        n_swap++;
      end
      advance();
    end
    checks++;
    if (n_swap !== 6 || bad_gap !== 0) begin
      errors++;
      $display("FAIL b2b_rate got swaps=%0d bad_gaps=%0d exp swaps=6 bad_gaps=0", n_swap, bad_gap);
    end
`ifdef SYNC_FRAME_CNT_EN
    checks++;
    if (cnt_a !== 16'd6 || cnt_b !== 2'd2) begin
      errors++;
      $display("FAIL b2b_wrap got=%0d/%0d exp=6/2", cnt_a, cnt_b);
    end
`endif
  endtask

  task automatic test_reset_in_ready();
    int n_swap = 0;
    int restart = -1;
    for (int k = 0; k < 14; k++) begin
      rst = (k == 0 || k == 7); ld = (k == 4); rd = (k == 4); br = (k > 7);
      model_expect();
      checks++;
      if ({ls_a, rs_a, sw_a, ls_b, rs_b, sw_b} !== {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap}) begin
        errors++;
        $display("FAIL rst_ready_pulses k=%0d got=%b exp=%b", k, {ls_a, rs_a, sw_a, ls_b, rs_b, sw_b}, {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap});
      end
      if (sw_a) n_swap++;
      if (ls_a && k > 7 && restart < 0) restart = k;
      advance();
    end
    checks++;
    if (n_swap !== 0 || restart !== 9) begin
      errors++;
      $display("FAIL rst_ready_seq got swaps=%0d restart=%0d exp swaps=0 restart=9", n_swap, restart);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst = (k == 0) || ($urandom_range(199) == 0);
      ld  = ($urandom_range(3) == 0);
      rd  = ($urandom_range(3) == 0);
      br  = ($urandom_range(1) == 0);
      model_expect();
      checks++;
      if ({ls_a, rs_a, sw_a, ls_b, rs_b, sw_b} !== {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap}) begin
        errors++;
        $display("FAIL rand_pulses k=%0d got=%b exp=%b", k, {ls_a, rs_a, sw_a, ls_b, rs_b, sw_b}, {exp_start, exp_start, exp_swap, exp_start, exp_start, exp_swap});
      end
      checks++;
      if ((ls_a & sw_a) !== 1'b0) begin
        errors++;
        $display("FAIL rand_exclusive k=%0d got start=%b swap=%b exp not both", k, ls_a, sw_a);
      end
`ifdef SYNC_FRAME_CNT_EN
      if (k > 0) begin
        checks++;
        if (cnt_a !== 16'(m_frames) || cnt_b !== 2'(m_frames)) begin
          errors++;
          $display("FAIL rand_count k=%0d got=%0d/%0d exp=%0d/%0d", k, cnt_a, cnt_b, 16'(m_frames), 2'(m_frames));
        end
      end
`endif
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; rd = 1'b0; br = 1'b0;
    #1;
    test_reset();
    test_seq_done();
    test_ready_late();
    test_back_to_back();
    test_reset_in_ready();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
